// File: rtl/cspi_mst.sv
// SPI master, mode 0, MSB first: bytes in over a valid/ready port, MISO bytes out as strobes.
// Chip-select stays low across a frame until a byte tagged tx_last has been shifted.
module cspi_mst #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic [7:0] rx_q,
  output logic       rx_qvld,
  output logic       busy,
  output logic       spi_csn,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          tx_last_q, tx_last_d;
  logic [7:0]    rx_q_q, rx_q_d;
  logic          rx_qvld_q, rx_qvld_d;
  logic          csn_q, csn_d;
  logic          sck_q, sck_d;
  logic          busy_q, busy_d;
  logic          rdy_en_q;

  logic tick, gap_done, accept;

  // Handshake: a byte moves on a clk_sys edge where tx_vld && tx_rdy; tx_rdy
  // depends on state only, and the source must hold tx_vld/tx_data until then.
  assign tx_rdy   = rdy_en_q & ((state_q == S_IDLE) | (state_q == S_WAIT));
  assign accept   = tx_vld & tx_rdy;
  assign tick     = (cnt_q == CW'(CLK_DIV - 1));
  assign gap_done = (cnt_q == CW'(CS_GAP - 1));

  // MOSI is the shift register MSB, so it is registered and resets to 0.
  assign spi_mosi = tx_sr_q[7];
  assign spi_csn  = csn_q;
  assign spi_sck  = sck_q;
  assign rx_q     = rx_q_q;
  assign rx_qvld  = rx_qvld_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    tx_last_d = tx_last_q;
    rx_q_d    = rx_q_q;
    rx_qvld_d = 1'b0;
    csn_d     = csn_q;
    sck_d     = sck_q;
    unique case (state_q)
      S_IDLE, S_WAIT: begin
        cnt_d = '0;
        if (accept) begin
          tx_sr_d   = tx_data;
          tx_last_d = tx_last;
          bit_d     = 3'd0;
          csn_d     = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        // Sampling at the end of the high phase gives a slow slave the most settling time.
        if (tick) begin
          cnt_d   = '0;
          sck_d   = 1'b0;
          rx_sr_d = {rx_sr_q[6:0], spi_miso};
          if (bit_q != 3'd7) tx_sr_d = {tx_sr_q[6:0], 1'b0};
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            sck_d   = 1'b1;
            state_d = S_HIGH;
          end else begin
            rx_q_d    = rx_sr_q;
            rx_qvld_d = 1'b1;
            if (tx_last_q) begin
              csn_d   = 1'b1;
              state_d = S_GAP;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      tx_last_q <= 1'b0;
      rx_q_q    <= 8'h00;
      rx_qvld_q <= 1'b0;
      csn_q     <= 1'b1;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      tx_last_q <= tx_last_d;
      rx_q_q    <= rx_q_d;
      rx_qvld_q <= rx_qvld_d;
      csn_q     <= csn_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      rdy_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cspi_mst.sv
// Directed bench for cspi_mst: instance A (CLK_DIV=4, CS_GAP=8) with a mode-0 slave model,
// instance B (CLK_DIV=2, CS_GAP=1) with MOSI looped back to MISO.
module tb_cspi_mst;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  logic [7:0] tx_data_a, rx_q_a;
  logic       tx_last_a, tx_vld_a, tx_rdy_a, rx_qvld_a, busy_a;
  logic       csn_a, sck_a, mosi_a, miso_a;
  logic [7:0] tx_data_b, rx_q_b;
  logic       tx_last_b, tx_vld_b, tx_rdy_b, rx_qvld_b, busy_b;
  logic       csn_b, sck_b, mosi_b, miso_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  cspi_mst #(.CLK_DIV(4), .CS_GAP(8)) dut_a (
    .clk_sys(clk_sys), .rst(rst),
    .tx_data(tx_data_a), .tx_last(tx_last_a), .tx_vld(tx_vld_a), .tx_rdy(tx_rdy_a),
    .rx_q(rx_q_a), .rx_qvld(rx_qvld_a), .busy(busy_a),
    .spi_csn(csn_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  cspi_mst #(.CLK_DIV(2), .CS_GAP(1)) dut_b (
    .clk_sys(clk_sys), .rst(rst),
    .tx_data(tx_data_b), .tx_last(tx_last_b), .tx_vld(tx_vld_b), .tx_rdy(tx_rdy_b),
    .rx_q(rx_q_b), .rx_qvld(rx_qvld_b), .busy(busy_b),
    .spi_csn(csn_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  assign miso_b = mosi_b;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Mode-0 slave for A: presents slv[byte] MSB first, advances on each SCK fall,
  // and records MOSI at every SCK rise.
  logic [7:0] slv [4];
  logic       sck_prev_a = 1'b0;
  logic [7:0] mcap_a = 8'h00;
  int         rise_a = 0;
  int         qvld_cnt_a = 0;
  int         sidx = 0;
  int         sbyte = 0;

  always @(negedge clk_sys) begin
    if (!sck_prev_a && sck_a) begin
      rise_a = rise_a + 1;
      mcap_a = {mcap_a[6:0], mosi_a};
    end
    if (rx_qvld_a) qvld_cnt_a = qvld_cnt_a + 1;
    if (csn_a) begin
      sidx  = 0;
      sbyte = 0;
    end else if (sck_prev_a && !sck_a) begin
      sidx = sidx + 1;
      if (sidx == 8) begin
        sidx  = 0;
        sbyte = sbyte + 1;
      end
    end
    sck_prev_a = sck_a;
    miso_a     = slv[sbyte % 4][7 - sidx];
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic acc_a();
    int n;
    n = 0;
    while (!tx_rdy_a && n < 500) begin
      step();
      n++;
    end
    chk("acc_a_ready", 32'(tx_rdy_a), 1);
    step();
  endtask

  task automatic acc_b();
    int n;
    n = 0;
    while (!tx_rdy_b && n < 500) begin
      step();
      n++;
    end
    chk("acc_b_ready", 32'(tx_rdy_b), 1);
    step();
  endtask

  task automatic wait_qvld_a(output int n, output int csn_hi);
    n = 0;
    csn_hi = 0;
    do begin
      step();
      n++;
      if (!rx_qvld_a && csn_a) csn_hi++;
    end while (!rx_qvld_a && n < 2000);
  endtask

  task automatic run_b(input logic [7:0] d);
    int n, run, bad, hi;
    logic prev;
    tx_data_b = d;
    tx_last_b = 1'b1;
    tx_vld_b  = 1'b1;
    acc_b();
    tx_vld_b = 1'b0;
    prev = sck_b;
    run = 1; bad = 0; hi = 0; n = 0;
    do begin
      step();
      n++;
      if (sck_b === prev) run++;
      else begin
        if (prev) hi++;
        if (run != 2) bad++;
        prev = sck_b;
        run  = 1;
      end
    end while (!rx_qvld_b && n < 500);
    chk("b_latency", n, 34);
    chk("b_loopback_rx", rx_q_b, {24'h0, d});
    chk("b_phase_len", bad, 0);
    chk("b_high_phases", hi, 8);
    n = 0;
    while (!tx_rdy_b && n < 100) begin
      step();
      n++;
    end
    chk("b_gap_len", n, 1);
  endtask

  initial begin
    int n, h, q0, r0, qc, bad;
    rst = 1'b1;
    tx_data_a = 8'h00; tx_last_a = 1'b0; tx_vld_a = 1'b0;
    tx_data_b = 8'h00; tx_last_b = 1'b0; tx_vld_b = 1'b0;
    slv[0] = 8'h00; slv[1] = 8'h00; slv[2] = 8'h00; slv[3] = 8'h00;

    // reset state
    repeat (3) step();
    chk("rst_csn", csn_a, 1);
    chk("rst_sck", sck_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_tx_rdy", tx_rdy_a, 0);
    chk("rst_qvld", rx_qvld_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rx_q", rx_q_a, 0);
    rst = 1'b0;
    step();
    chk("rel_tx_rdy", tx_rdy_a, 1);

    // single byte 0xA5, slave answers 0x3C
    slv[0] = 8'h3C;
    tx_data_a = 8'hA5; tx_last_a = 1'b1; tx_vld_a = 1'b1;
    r0 = rise_a;
    acc_a();
    tx_vld_a = 1'b0;
    chk("t1_csn_low", csn_a, 0);
    chk("t1_mosi_bit7", mosi_a, 1);
    chk("t1_busy", busy_a, 1);
    chk("t1_rdy_low", tx_rdy_a, 0);
    wait_qvld_a(n, h);
    chk("t1_latency", n, 68);
    chk("t1_rx_q", rx_q_a, 8'h3C);
    chk("t1_csn_at_qvld", csn_a, 1);
    chk("t1_mosi_bits", mcap_a, 8'hA5);
    chk("t1_sck_rises", rise_a - r0, 8);

    // byte offered during the gap: ready only after CS_GAP cycles
    tx_data_a = 8'h01; tx_last_a = 1'b0; tx_vld_a = 1'b1;
    n = 0; h = 0;
    while (!tx_rdy_a && n < 200) begin
      step();
      n++;
      if (!csn_a) h++;
    end
    chk("gap_len", n, 8);
    chk("gap_csn_high", h, 0);

    // three-byte frame with tx_vld held high
    slv[0] = 8'hC3; slv[1] = 8'h5A; slv[2] = 8'h99;
    r0 = rise_a;
    acc_a();
    tx_data_a = 8'h80;
    wait_qvld_a(n, h);
    q0 = cyc;
    chk("f0_latency", n, 68);
    chk("f0_rx_q", rx_q_a, 8'hC3);
    chk("f0_mosi_bits", mcap_a, 8'h01);
    chk("f0_csn_low", h, 0);
    chk("f0_rdy_in_wait", tx_rdy_a, 1);
    chk("f0_csn_at_qvld", csn_a, 0);
    acc_a();
    tx_data_a = 8'hFF; tx_last_a = 1'b1;
    wait_qvld_a(n, h);
    chk("f1_spacing", cyc - q0, 69);
    chk("f1_rx_q", rx_q_a, 8'h5A);
    chk("f1_mosi_bits", mcap_a, 8'h80);
    chk("f1_csn_low", h, 0);
    q0 = cyc;
    acc_a();
    tx_vld_a = 1'b0;
    wait_qvld_a(n, h);
    chk("f2_spacing", cyc - q0, 69);
    chk("f2_rx_q", rx_q_a, 8'h99);
    chk("f2_mosi_bits", mcap_a, 8'hFF);
    chk("f2_csn_low", h, 0);
    chk("f2_csn_at_qvld", csn_a, 1);
    chk("frame_sck_rises", rise_a - r0, 24);

    // non-last byte, then the source goes quiet for 50 cycles
    slv[0] = 8'h69; slv[1] = 8'hA7;
    tx_data_a = 8'h96; tx_last_a = 1'b0; tx_vld_a = 1'b1;
    acc_a();
    tx_vld_a = 1'b0;
    wait_qvld_a(n, h);
    chk("w0_rx_q", rx_q_a, 8'h69);
    chk("w0_mosi_bits", mcap_a, 8'h96);
    bad = 0;
    repeat (50) begin
      step();
      if (csn_a !== 1'b0 || sck_a !== 1'b0 || tx_rdy_a !== 1'b1 || busy_a !== 1'b1) bad++;
    end
    chk("wait_hold", bad, 0);
    tx_data_a = 8'h3A; tx_last_a = 1'b1; tx_vld_a = 1'b1;
    acc_a();
    tx_vld_a = 1'b0;
    chk("w1_setup_sck", sck_a, 0);
    chk("w1_setup_csn", csn_a, 0);
    wait_qvld_a(n, h);
    chk("w1_latency", n, 68);
    chk("w1_rx_q", rx_q_a, 8'hA7);
    chk("w1_mosi_bits", mcap_a, 8'h3A);

    // reset during bit 4 of an all-ones byte
    slv[0] = 8'h00;
    tx_data_a = 8'hFF; tx_last_a = 1'b1; tx_vld_a = 1'b1;
    acc_a();
    tx_vld_a = 1'b0;
    repeat (38) step();
    chk("r_sck_before", sck_a, 1);
    chk("r_mosi_before", mosi_a, 1);
    qc = qvld_cnt_a;
    rst = 1'b1;
    #1;
    chk("r_csn", csn_a, 1);
    chk("r_sck", sck_a, 0);
    chk("r_mosi", mosi_a, 0);
    chk("r_tx_rdy", tx_rdy_a, 0);
    chk("r_busy", busy_a, 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("r_rel_tx_rdy", tx_rdy_a, 1);
    chk("r_no_qvld", qvld_cnt_a - qc, 0);
    slv[0] = 8'h81;
    tx_data_a = 8'h5C; tx_last_a = 1'b1; tx_vld_a = 1'b1;
    acc_a();
    tx_vld_a = 1'b0;
    wait_qvld_a(n, h);
    chk("r2_latency", n, 68);
    chk("r2_rx_q", rx_q_a, 8'h81);
    chk("r2_mosi_bits", mcap_a, 8'h5C);

    // CLK_DIV=2, CS_GAP=1 corner with loopback
    run_b(8'h00);
    run_b(8'hFF);
    run_b(8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
